// File: rtl/k_l_window_drain_pkg.sv
// Shared definitions for the k/l anonymizer window drain stage.
// Drain state encoding and the fully-masked q_id mask value.
package k_l_window_drain_pkg;

  localparam int unsigned ADDR_WIDTH_DEF      = 12;
  localparam int unsigned Q_ID_WIDTH_DEF      = 32;
  localparam int unsigned Q_ID_MASK_WIDTH_DEF = 6;
  localparam int unsigned S_ATTR_WIDTH_DEF    = 32;

  // Mask count meaning every q_id bit is suppressed; the anonymizer uses the same value.
  localparam int unsigned Q_ID_MASK_ALL = Q_ID_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

endpackage

// File: rtl/k_l_out_fifo.sv
// Two-entry registered FIFO; the head entry drives the output stream directly.
module k_l_out_fifo #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] tail_q;
  logic                  tail_vld;
  logic                  pop_c;

  assign pop_c = pop & head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      tail_vld   <= 1'b0;
      tail_q     <= '0;
      occupancy  <= 2'd0;
    end else begin
      occupancy <= occupancy + 2'(push) - 2'(pop_c);
      if (pop_c) begin
        // Tail moves up to head; a simultaneous push refills whichever slot frees up.
        if (tail_vld) begin
          head_data  <= tail_q;
          head_valid <= 1'b1;
          tail_vld   <= push;
          if (push) tail_q <= push_data;
        end else begin
          head_valid <= push;
          if (push) head_data <= push_data;
        end
      end else if (push) begin
        if (!head_valid) begin
          head_data  <= push_data;
          head_valid <= 1'b1;
        end else begin
          tail_q   <= push_data;
          tail_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/k_l_window_drain.sv
// Drains one anonymized window from the k/l anonymizer buffer onto a valid/ready stream.
// Optional K_L_DRAIN_STATS_EN adds supp_count (fully masked tuples per window).
module k_l_window_drain
  import k_l_window_drain_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned Q_ID_WIDTH      = Q_ID_WIDTH_DEF,
  parameter int unsigned Q_ID_MASK_WIDTH = Q_ID_MASK_WIDTH_DEF,
  parameter int unsigned S_ATTR_WIDTH    = S_ATTR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH:0]        window_size,
  input  logic                       all_finished,
  output logic [ADDR_WIDTH-1:0]      read_address,
  input  logic [Q_ID_WIDTH-1:0]      q_id_in,
  input  logic [Q_ID_MASK_WIDTH-1:0] q_id_mask_in,
  input  logic [S_ATTR_WIDTH-1:0]    s_attr_in,
  output logic                       write_allow,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [Q_ID_WIDTH-1:0]      m_q_id,
  output logic [Q_ID_MASK_WIDTH-1:0] m_q_id_mask,
  output logic [S_ATTR_WIDTH-1:0]    m_s_attr,
  output logic                       m_last,
  output logic                       window_done,
`ifdef K_L_DRAIN_STATS_EN
  output logic [ADDR_WIDTH:0]        supp_count,
`endif
  output logic                       proto_err
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned DATA_W = 1 + Q_ID_MASK_WIDTH + Q_ID_WIDTH + S_ATTR_WIDTH;
  localparam logic [CNT_W-1:0] MAX_WIN = CNT_W'(1) << ADDR_WIDTH;

  drain_state_e state_q, state_d;
  logic             done_d;
  logic [CNT_W-1:0] win_q, issue_cnt_q, win_clamped_c;
  logic             inflight_q, inflight_last_q;
  logic             start_c, issue_c, pop_c, last_pop_c;
  logic [1:0]       occupancy;
  logic [2:0]       credit_used_c;
  logic [DATA_W-1:0] head_data;

  assign win_clamped_c = (window_size > MAX_WIN) ? MAX_WIN : window_size;
  assign start_c       = (state_q == ARMED) && all_finished;
  assign pop_c         = m_valid && m_ready;
  assign last_pop_c    = pop_c && m_last;

  // A transfer this cycle frees a slot, so count it back to sustain one tuple per cycle.
  assign credit_used_c = 3'(occupancy) + 3'(inflight_q);
  assign issue_c       = (state_q == DRAIN) && (issue_cnt_q < win_q) &&
                         (credit_used_c < (3'd2 + 3'(pop_c)));

  assign read_address = issue_cnt_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!all_finished) state_d = ARMED;
      end
      ARMED: begin
        if (all_finished) begin
          if (win_clamped_c == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_pop_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered control outputs and the issue side of the read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_done     <= 1'b0;
      write_allow     <= 1'b1;
      proto_err       <= 1'b0;
      win_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      window_done     <= done_d;
      write_allow     <= (state_d != DRAIN);
      proto_err       <= proto_err | ((state_q == DRAIN) && !all_finished);
      inflight_q      <= issue_c;
      inflight_last_q <= issue_c && (issue_cnt_q == (win_q - CNT_W'(1)));
      if (start_c) begin
        win_q       <= win_clamped_c;
        issue_cnt_q <= '0;
      end else if (issue_c) begin
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
    end
  end

  k_l_out_fifo #(
    .DATA_WIDTH (DATA_W)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_data  ({inflight_last_q, q_id_mask_in, q_id_in, s_attr_in}),
    .pop        (pop_c),
    .head_valid (m_valid),
    .head_data  (head_data),
    .occupancy  (occupancy)
  );

  assign m_last      = head_data[DATA_W-1];
  assign m_q_id_mask = head_data[S_ATTR_WIDTH+Q_ID_WIDTH +: Q_ID_MASK_WIDTH];
  assign m_q_id      = head_data[S_ATTR_WIDTH +: Q_ID_WIDTH];
  assign m_s_attr    = head_data[S_ATTR_WIDTH-1:0];

`ifdef K_L_DRAIN_STATS_EN
  // Fully masked tuples counted as they are accepted; held until the next drain starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      supp_count <= '0;
    end else if (start_c) begin
      supp_count <= '0;
    end else if (pop_c && (m_q_id_mask == Q_ID_MASK_WIDTH'(Q_ID_MASK_ALL))) begin
      supp_count <= supp_count + CNT_W'(1);
    end
  end
`endif

endmodule
